// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, and press/release/long-hold pulses.
// Every output is registered. The pulses come from one FSM transition each, so no two of them can be high in the same cycle.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 250_000,
    parameter int LONG_CYC     = 25_000_000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic btn_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int LW = $clog2(LONG_CYC + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYC);
    localparam logic [LW-1:0] LONG_PEN = LW'(LONG_CYC - 1);
    localparam logic          REL_LVL  = ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic            sync1_reg, sync2_reg;
    logic            s;
    logic            deb_done;
    logic [DW-1:0]   deb_cnt_reg, deb_cnt_next;
    logic [LW-1:0]   long_cnt_reg, long_cnt_next;
    logic            long_done_reg, long_done_next;
    logic            btn_next, press_next, release_next, long_next;

    // The synchronizer resets to the released pin level, so an idle button produces no event when reset is released.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_reg <= REL_LVL;
            sync2_reg <= REL_LVL;
        end else begin
            sync1_reg <= btn_i;
            sync2_reg <= sync1_reg;
        end
    end

    assign s        = ACTIVE_LOW ? ~sync2_reg : sync2_reg;
    assign deb_done = (deb_cnt_reg == DEB_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            deb_cnt_reg   <= '0;
            long_cnt_reg  <= '0;
            long_done_reg <= 1'b0;
            btn_o         <= 1'b0;
            press_o       <= 1'b0;
            release_o     <= 1'b0;
            long_o        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            deb_cnt_reg   <= deb_cnt_next;
            long_cnt_reg  <= long_cnt_next;
            long_done_reg <= long_done_next;
            btn_o         <= btn_next;
            press_o       <= press_next;
            release_o     <= release_next;
            long_o        <= long_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        deb_cnt_next = deb_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (s) begin
                    state_next   = PRESS_WAIT;
                    deb_cnt_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s)            state_next   = IDLE;
                else if (deb_done) state_next   = PRESSED;
                else               deb_cnt_next = deb_cnt_reg + 1'b1;
            end
            PRESSED: begin
                if (!s) begin
                    state_next   = RELEASE_WAIT;
                    deb_cnt_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s)             state_next   = PRESSED;
                else if (deb_done) state_next   = IDLE;
                else               deb_cnt_next = deb_cnt_reg + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // The long counter holds in RELEASE_WAIT so that a bounce while the button is held only pauses the hold timer.
    always_comb begin
        press_next     = (state_reg == PRESS_WAIT)   && (state_next == PRESSED);
        release_next   = (state_reg == RELEASE_WAIT) && (state_next == IDLE);
        btn_next       = btn_o;
        long_cnt_next  = long_cnt_reg;
        long_done_next = long_done_reg;
        long_next      = 1'b0;
        if (press_next) begin
            btn_next      = 1'b1;
            long_cnt_next = '0;
        end
        if (release_next) begin
            btn_next       = 1'b0;
            long_done_next = 1'b0;
        end
        if ((state_reg == PRESSED) && (long_cnt_reg != LONG_MAX)) begin
            long_cnt_next = long_cnt_reg + 1'b1;
            if ((long_cnt_reg == LONG_PEN) && !long_done_reg) begin
                long_next      = 1'b1;
                long_done_next = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_btn_debounce.sv
// Randomised bench for btn_debounce. A run-length reference model predicts the events and a negedge monitor scores the DUT pulses against them.
module tb_btn_debounce;
    localparam int D = 4;
    localparam int L = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;
    logic btn_o, press_o, release_o, long_o;

    btn_debounce #(.DEBOUNCE_CYC(D), .LONG_CYC(L), .ACTIVE_LOW(1'b1)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .btn_i    (btn),
        .btn_o    (btn_o),
        .press_o  (press_o),
        .release_o(release_o),
        .long_o   (long_o)
    );

    always #5 clk = ~clk;

    // kind: 0 = press, 1 = release, 2 = long
    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    // The reference model works on sampled button level s: a level change is accepted once s has held the new value for D+1 consecutive samples.
    // Hold time is counted while the accepted level is "pressed" and the previous sample was also pressed.
    bit  m_h1 = 1'b1, m_h2 = 1'b1;
    bit  m_level = 1'b0, m_run_val = 1'b0, m_prev_s = 1'b0, m_long_fired = 1'b0;
    int  m_run_len = 0, m_held = 0;

    task automatic push_ev(input int kind);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    initial forever begin
        bit s;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_h1 = 1'b1; m_h2 = 1'b1;
            m_level = 1'b0; m_run_val = 1'b0; m_prev_s = 1'b0; m_long_fired = 1'b0;
            m_run_len = 0; m_held = 0;
        end else begin
            cyc++;
            s    = !m_h2;
            m_h2 = m_h1;
            m_h1 = btn;
            if (s == m_run_val) m_run_len++;
            else begin
                m_run_val = s;
                m_run_len = 1;
            end
            if (m_level && m_prev_s && m_held < L) begin
                m_held++;
                if (m_held == L && !m_long_fired) begin
                    m_long_fired = 1'b1;
                    push_ev(2);
                end
            end
            if (!m_level && s && m_run_len == D + 1) begin
                m_level = 1'b1;
                m_held  = 0;
                push_ev(0);
            end else if (m_level && !s && m_run_len == D + 1) begin
                m_level      = 1'b0;
                m_long_fired = 1'b0;
                push_ev(1);
            end
            m_prev_s = s;
        end
    end

    initial forever begin
        int  n;
        int  act;
        ev_t e;
        @(negedge clk);
        if (!rst) begin
            checks++;
            if (btn_o !== m_level) begin
                errors++;
                $display("FAIL level cyc=%0d btn_o=%b want %b", cyc, btn_o, m_level);
            end
            n = int'(press_o) + int'(release_o) + int'(long_o);
            if (n > 1) begin
                checks++;
                errors++;
                $display("FAIL exclusive cyc=%0d press=%b release=%b long=%b want at most one", cyc, press_o, release_o, long_o);
            end
            if (n != 0 || exp_q.size() != 0) begin
                checks++;
                act = press_o ? 0 : (release_o ? 1 : 2);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected cyc=%0d got kind=%0d want none", cyc, act);
                end else begin
                    e = exp_q.pop_front();
                    if (n == 0) begin
                        errors++;
                        $display("FAIL missing cyc=%0d got none want kind=%0d", cyc, e.kind);
                    end else if (act != e.kind) begin
                        errors++;
                        $display("FAIL event cyc=%0d got kind=%0d want kind=%0d", cyc, act, e.kind);
                    end
                end
            end
        end
    end

    task automatic drive(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            btn = b;
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #7;
        rst = 1'b1;
        #1;
        checks++;
        if ({btn_o, press_o, release_o, long_o} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset outs=%b want 0000", {btn_o, press_o, release_o, long_o});
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        logic lvl;
        rst = 1'b1;
        btn = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({btn_o, press_o, release_o, long_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state outs=%b want 0000", {btn_o, press_o, release_o, long_o});
        end

        drive(1'b1, 10);
        drive(1'b0, 40);                 // press, single long pulse, saturation
        drive(1'b1, 20);                 // release
        drive(1'b0, 3);                  // short glitch: nothing
        drive(1'b1, 15);
        drive(1'b0, 12);                 // press
        repeat (6) begin                 // 2-cycle bounces while held
            drive(1'b1, 2);
            drive(1'b0, 3);
        end
        drive(1'b0, 15);
        drive(1'b1, 15);
        drive(1'b0, 15);                 // press, then reset while held
        async_reset();
        drive(1'b0, 20);                 // requalified press after reset
        drive(1'b1, 20);

        lvl = 1'b0;
        repeat (200) begin
            if ($urandom_range(0, 9) == 0) drive(lvl, $urandom_range(15, 40));
            else                           drive(lvl, $urandom_range(1, 14));
            lvl = !lvl;
        end
        drive(1'b1, 30);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
